oled_spi_cmd_rx: RTL and testbench

SPI-slave receiver and SSD1306-style command decoder: the display-side endpoint of the OLED power-on/init link. Oversamples SCLK/MOSI/CS/DC in the clk domain, assembles MSB-first bytes, and splits them by DC into command bytes (opcode + optional argument) or display-data bytes. Data bytes carry a column/page address. Used as the on-FPGA display model and as the checker for the init sequencer.

---
 rtl/oled_cmd_pkg.sv | 31 +++
 rtl/oled_spi_cmd_rx_byte_rx.sv | 87 ++++++++
 rtl/oled_spi_cmd_rx.sv | 150 +++++++++++++++
 tb/tb_oled_spi_cmd_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_cmd_pkg.sv
// Shared opcodes, address-mode encodings, decoder states and reset values
// for the SSD1306-style command receiver.
package oled_cmd_pkg;

    localparam logic [7:0] OP_CONTRAST = 8'h81;
    localparam logic [7:0] OP_MUX      = 8'hA8;
    localparam logic [7:0] OP_OFFSET   = 8'hD3;
    localparam logic [7:0] OP_CPUMP    = 8'h8D;
    localparam logic [7:0] OP_ADDRMODE = 8'h20;
    localparam logic [7:0] OP_DISP_OFF = 8'hAE;
    localparam logic [7:0] OP_DISP_ON  = 8'hAF;

    localparam logic [1:0] AM_HORIZ = 2'd0;
    localparam logic [1:0] AM_VERT  = 2'd1;
    localparam logic [1:0] AM_PAGE  = 2'd2;

    localparam logic [5:0] MUX_RST      = 6'd63;
    localparam logic [7:0] CONTRAST_RST = 8'h7F;
    localparam logic [1:0] AM_RST       = AM_PAGE;

    typedef enum logic {
        OP  = 1'b0,
        ARG = 1'b1
    } dec_state_e;

    function automatic logic is_two_byte(input logic [7:0] op);
        return (op == OP_CONTRAST) || (op == OP_MUX) || (op == OP_OFFSET) ||
               (op == OP_CPUMP) || (op == OP_ADDRMODE);
    endfunction

endpackage

// File: rtl/oled_spi_cmd_rx_byte_rx.sv
// SPI mode-0 slave byte assembler: synchronises the pins, detects SCLK
// rises and shifts MOSI in MSB-first; flags bytes cut short by CS.
module spi_slave_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       srst,
    input  logic       spi_cs_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       rx_dc,
    output logic       frame_err
);
    localparam int MS = SYNC_STAGES - 1;

    logic [MS:0] sclk_s, mosi_s, dc_s, cs_s;
    logic        sclk_d, rise_q, mosi_q, dc_q;
    logic [6:0]  shreg;
    logic [2:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= '0;
            mosi_s <= '0;
            dc_s   <= '0;
            cs_s   <= '1;
        end else begin
            sclk_s <= {sclk_s[MS-1:0], spi_sclk};
            mosi_s <= {mosi_s[MS-1:0], spi_mosi};
            dc_s   <= {dc_s[MS-1:0], spi_dc};
            cs_s   <= {cs_s[MS-1:0], spi_cs_n};
        end
    end

    // Rise strobe is registered together with the data it qualifies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            rise_q <= 1'b0;
            mosi_q <= 1'b0;
            dc_q   <= 1'b0;
        end else begin
            sclk_d <= sclk_s[MS];
            rise_q <= sclk_s[MS] & ~sclk_d & ~cs_s[MS] & ~srst;
            mosi_q <= mosi_s[MS];
            dc_q   <= dc_s[MS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            cnt        <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            rx_dc      <= 1'b0;
            frame_err  <= 1'b0;
        end else if (srst) begin
            shreg      <= '0;
            cnt        <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            rx_dc      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (cs_s[MS]) begin
                frame_err <= (cnt != 3'd0);
                cnt       <= '0;
            end else if (rise_q) begin
                shreg <= {shreg[5:0], mosi_q};
                cnt   <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    rx_byte    <= {shreg, mosi_q};
                    rx_dc      <= dc_q;
                end
            end
        end
    end

endmodule

// File: rtl/oled_spi_cmd_rx.sv
// SSD1306-style display endpoint: decodes received SPI bytes into commands,
// panel status registers and addressed display-data writes.
module oled_spi_cmd_rx
    import oled_cmd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COL_W       = 7,
    parameter int PAGE_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_dc,
    input  logic              oled_res_n,
    output logic              cmd_valid,
    output logic [7:0]        cmd_op,
    output logic [7:0]        cmd_arg,
    output logic              cmd_has_arg,
    output logic              data_valid,
    output logic [7:0]        data_byte,
    output logic [COL_W-1:0]  data_col,
    output logic [PAGE_W-1:0] data_page,
    output logic              disp_on,
    output logic              charge_pump_en,
    output logic [5:0]        mux_ratio,
    output logic [5:0]        disp_offset,
    output logic [5:0]        start_line,
    output logic [7:0]        contrast,
    output logic [1:0]        addr_mode,
    output logic              frame_err,
    output logic              proto_err
);
    localparam logic [COL_W-1:0]  COL_MAX  = '1;
    localparam logic [PAGE_W-1:0] PAGE_MAX = '1;

    logic [SYNC_STAGES-1:0] res_s;
    logic                   srst;
    logic                   byte_valid, rx_dc;
    logic [7:0]             rx_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_s <= '0;
        else        res_s <= {res_s[SYNC_STAGES-2:0], oled_res_n};
    end
    assign srst = ~res_s[SYNC_STAGES-1];

    spi_slave_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk(clk), .rst_n(rst_n), .srst(srst),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_dc(spi_dc),
        .byte_valid(byte_valid), .rx_byte(rx_byte),
        .rx_dc(rx_dc), .frame_err(frame_err)
    );

    dec_state_e        state, state_nx;
    logic [7:0]        pend, pend_nx;
    logic [COL_W-1:0]  col, col_nx;
    logic [PAGE_W-1:0] page, page_nx;
    logic              cv_nx, chas_nx, dv_nx, don_nx, cp_nx, pe_nx;
    logic [7:0]        cop_nx, carg_nx, db_nx, con_nx;
    logic [COL_W-1:0]  dcol_nx;
    logic [PAGE_W-1:0] dpage_nx;
    logic [5:0]        mux_nx, off_nx, sl_nx;
    logic [1:0]        am_nx;

    always_comb begin
        state_nx = state;   pend_nx = pend;
        col_nx   = col;     page_nx = page;
        cv_nx    = 1'b0;    dv_nx   = 1'b0;   pe_nx = 1'b0;
        cop_nx   = cmd_op;  carg_nx = cmd_arg; chas_nx = cmd_has_arg;
        db_nx    = data_byte;
        dcol_nx  = data_col; dpage_nx = data_page;
        don_nx   = disp_on; cp_nx   = charge_pump_en;
        mux_nx   = mux_ratio; off_nx = disp_offset; sl_nx = start_line;
        con_nx   = contrast; am_nx  = addr_mode;
        if (byte_valid && !rx_dc && state == OP) begin
            if (is_two_byte(rx_byte)) begin
                pend_nx  = rx_byte;
                state_nx = ARG;
            end else begin
                cv_nx = 1'b1; cop_nx = rx_byte;
                carg_nx = '0; chas_nx = 1'b0;
                unique case (1'b1)
                    rx_byte == OP_DISP_OFF:     don_nx = 1'b0;
                    rx_byte == OP_DISP_ON:      don_nx = 1'b1;
                    rx_byte[7:6] == 2'b01:      sl_nx = rx_byte[5:0];
                    rx_byte[7:3] == 5'b10110:   page_nx = rx_byte[PAGE_W-1:0];
                    rx_byte[7:4] == 4'h0:       col_nx[3:0] = rx_byte[3:0];
                    rx_byte[7:3] == 5'b00010:   col_nx[COL_W-1:4] = rx_byte[COL_W-5:0];
                    default: ;
                endcase
            end
        end else if (byte_valid && !rx_dc) begin
            cv_nx = 1'b1; cop_nx = pend;
            carg_nx = rx_byte; chas_nx = 1'b1;
            state_nx = OP;
            unique case (1'b1)
                pend == OP_CONTRAST: con_nx = rx_byte;
                pend == OP_MUX:      mux_nx = rx_byte[5:0];
                pend == OP_OFFSET:   off_nx = rx_byte[5:0];
                pend == OP_CPUMP:    cp_nx = rx_byte[2];
                pend == OP_ADDRMODE: begin
                    if (rx_byte[1:0] == 2'd3) pe_nx = 1'b1;
                    else                      am_nx = rx_byte[1:0];
                end
                default: ;
            endcase
        end else if (byte_valid) begin
            // A data byte while an argument is pending aborts the command
            pe_nx    = (state == ARG);
            state_nx = OP;
            dv_nx = 1'b1; db_nx = rx_byte;
            dcol_nx = col; dpage_nx = page;
            unique case (addr_mode)
                AM_HORIZ: begin
                    col_nx = col + 1'b1;
                    if (col == COL_MAX) page_nx = page + 1'b1;
                end
                AM_VERT: begin
                    page_nx = page + 1'b1;
                    if (page == PAGE_MAX) col_nx = col + 1'b1;
                end
                default: col_nx = col + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || srst) begin
            state <= OP; pend <= '0; col <= '0; page <= '0;
            cmd_valid <= 1'b0; cmd_op <= '0; cmd_arg <= '0; cmd_has_arg <= 1'b0;
            data_valid <= 1'b0; data_byte <= '0; data_col <= '0; data_page <= '0;
            disp_on <= 1'b0; charge_pump_en <= 1'b0; proto_err <= 1'b0;
            mux_ratio <= MUX_RST; disp_offset <= '0; start_line <= '0;
            contrast <= CONTRAST_RST; addr_mode <= AM_RST;
        end else begin
            state <= state_nx; pend <= pend_nx; col <= col_nx; page <= page_nx;
            cmd_valid <= cv_nx; cmd_op <= cop_nx; cmd_arg <= carg_nx;
            cmd_has_arg <= chas_nx;
            data_valid <= dv_nx; data_byte <= db_nx;
            data_col <= dcol_nx; data_page <= dpage_nx;
            disp_on <= don_nx; charge_pump_en <= cp_nx; proto_err <= pe_nx;
            mux_ratio <= mux_nx; disp_offset <= off_nx; start_line <= sl_nx;
            contrast <= con_nx; addr_mode <= am_nx;
        end
    end

endmodule

// File: tb/tb_oled_spi_cmd_rx.sv
// Directed bench for oled_spi_cmd_rx: command table, addressing runs,
// framing/protocol errors and display reset.
module tb_oled_spi_cmd_rx;
    logic       clk = 1'b0;
    logic       rst_n, spi_cs_n, spi_sclk, spi_mosi, spi_dc, oled_res_n;
    logic       cmd_valid, cmd_has_arg, data_valid, disp_on, charge_pump_en;
    logic [7:0] cmd_op, cmd_arg, data_byte, contrast;
    logic [6:0] data_col;
    logic [2:0] data_page;
    logic [5:0] mux_ratio, disp_offset, start_line;
    logic [1:0] addr_mode;
    logic       frame_err, proto_err;

    oled_spi_cmd_rx #(.SYNC_STAGES(2), .COL_W(7), .PAGE_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_dc(spi_dc), .oled_res_n(oled_res_n),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cmd_has_arg(cmd_has_arg), .data_valid(data_valid),
        .data_byte(data_byte), .data_col(data_col), .data_page(data_page),
        .disp_on(disp_on), .charge_pump_en(charge_pump_en),
        .mux_ratio(mux_ratio), .disp_offset(disp_offset),
        .start_line(start_line), .contrast(contrast), .addr_mode(addr_mode),
        .frame_err(frame_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, e0_cyc = 0, vcyc = 0;
    int ncmd = 0, ndata = 0, nfe = 0, npe = 0;
    logic [7:0] lop, larg;
    logic       lhas;

    typedef struct packed {
        logic [7:0] b;
        logic [6:0] c;
        logic [2:0] p;
    } dent_t;
    dent_t dq[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid) begin
                ncmd++; lop = cmd_op; larg = cmd_arg; lhas = cmd_has_arg;
                vcyc = cyc;
            end
            if (data_valid) begin
                ndata++; dq.push_back({data_byte, data_col, data_page});
            end
            if (frame_err) nfe++;
            if (proto_err) npe++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
        for (int k = 0; k < n; k++) begin
            spi_mosi = b[7-k];
            spi_dc   = dc;
            repeat (3) @(posedge clk);
            #1 spi_sclk = 1'b1;
            if (k == n - 1) e0_cyc = cyc + 1;
            repeat (3) @(posedge clk);
            #1 spi_sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, dc, 8);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    function automatic logic [31:0] fld(input int f);
        case (f)
            0: return {31'd0, disp_on};
            1: return {31'd0, charge_pump_en};
            2: return {26'd0, mux_ratio};
            3: return {26'd0, disp_offset};
            4: return {26'd0, start_line};
            5: return {24'd0, contrast};
            default: return {30'd0, addr_mode};
        endcase
    endfunction

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic       two;
        logic [7:0] e_op;
        logic [7:0] e_arg;
        logic       e_has;
        int         f;
        logic [7:0] e_val;
    } vec_t;
    vec_t tbl[8];

    task automatic send_data_check(input logic [7:0] b, input logic [6:0] c,
                                   input logic [2:0] p, input string nm);
        dq.delete();
        send_byte(b, 1'b1);
        settle();
        chk({nm, "_n"}, dq.size(), 1);
        if (dq.size() == 1) chk(nm, dq[0], {b, c, p});
    endtask

    initial begin
        int n0, d0, f0, p0;
        tbl[0] = '{8'hAF, 8'h00, 1'b0, 8'hAF, 8'h00, 1'b0, 0, 8'h01};
        tbl[1] = '{8'hA8, 8'h3F, 1'b1, 8'hA8, 8'h3F, 1'b1, 2, 8'h3F};
        tbl[2] = '{8'h8D, 8'h14, 1'b1, 8'h8D, 8'h14, 1'b1, 1, 8'h01};
        tbl[3] = '{8'h81, 8'h20, 1'b1, 8'h81, 8'h20, 1'b1, 5, 8'h20};
        tbl[4] = '{8'hD3, 8'h05, 1'b1, 8'hD3, 8'h05, 1'b1, 3, 8'h05};
        tbl[5] = '{8'h52, 8'h00, 1'b0, 8'h52, 8'h00, 1'b0, 4, 8'h12};
        tbl[6] = '{8'hAE, 8'h00, 1'b0, 8'hAE, 8'h00, 1'b0, 0, 8'h00};
        tbl[7] = '{8'h20, 8'h00, 1'b1, 8'h20, 8'h00, 1'b1, 6, 8'h00};

        rst_n = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0;
        spi_mosi = 1'b0; spi_dc = 1'b0; oled_res_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_contrast", contrast, 8'h7F);
        chk("rst_mux", mux_ratio, 63);
        chk("rst_addr_mode", addr_mode, 2);
        chk("rst_disp_on", disp_on, 0);
        chk("rst_cmd_op", cmd_op, 0);
        @(posedge clk); #1 spi_cs_n = 1'b0;
        repeat (4) @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            n0 = ncmd;
            send_byte(tbl[i].b0, 1'b0);
            if (tbl[i].two) send_byte(tbl[i].b1, 1'b0);
            settle();
            chk($sformatf("v%0d_count", i), ncmd, n0 + 1);
            chk($sformatf("v%0d_op", i), lop, tbl[i].e_op);
            chk($sformatf("v%0d_arg", i), larg, tbl[i].e_arg);
            chk($sformatf("v%0d_has", i), lhas, tbl[i].e_has);
            chk($sformatf("v%0d_field", i), fld(tbl[i].f), tbl[i].e_val);
            if (i == 0) chk("latency", vcyc - e0_cyc, 4);
        end

        // Horizontal run across the page boundary
        dq.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 130; i++) send_byte(i[7:0], 1'b1);
        settle();
        chk("horiz_n", dq.size(), 130);
        for (int i = 0; i < 130 && i < dq.size(); i++)
            chk($sformatf("horiz_%0d", i), dq[i],
                {i[7:0], i[6:0], (i >= 128) ? 3'd1 : 3'd0});

        n0 = ncmd; p0 = npe;
        send_byte(8'h20, 1'b0); send_byte(8'h03, 1'b0);
        settle();
        chk("am3_cmd", ncmd, n0 + 1);
        chk("am3_proto", npe, p0 + 1);
        chk("am3_mode", addr_mode, 0);

        // Vertical mode from the last cell wraps to (0,0)
        send_byte(8'h20, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'hB7, 1'b0); send_byte(8'h0F, 1'b0); send_byte(8'h17, 1'b0);
        settle();
        chk("vert_mode", addr_mode, 1);
        send_data_check(8'hA1, 7'd127, 3'd7, "vert_a");
        send_data_check(8'hA2, 7'd0, 3'd0, "vert_b");

        // Page mode wraps the column only
        send_byte(8'h20, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'hB3, 1'b0); send_byte(8'h0F, 1'b0); send_byte(8'h17, 1'b0);
        settle();
        send_data_check(8'hB1, 7'd127, 3'd3, "page_a");
        send_data_check(8'hB2, 7'd0, 3'd3, "page_b");

        // Chip select rising mid-byte
        send_byte(8'hAF, 1'b0);
        settle();
        chk("fe_pre_disp", disp_on, 1);
        n0 = ncmd; d0 = ndata; f0 = nfe;
        send_bits(8'hAE, 1'b0, 5);
        @(posedge clk); #1 spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("fe_count", nfe, f0 + 1);
        chk("fe_no_cmd", ncmd, n0);
        chk("fe_no_data", ndata, d0);
        @(posedge clk); #1 spi_cs_n = 1'b0;
        repeat (4) @(posedge clk); #1;
        send_byte(8'hAE, 1'b0);
        settle();
        chk("fe_op", lop, 8'hAE);
        chk("fe_disp", disp_on, 0);
        chk("fe_single", nfe, f0 + 1);

        // Data byte while an argument is pending
        n0 = ncmd; d0 = ndata; p0 = npe;
        send_byte(8'hD3, 1'b0);
        dq.delete();
        send_byte(8'h55, 1'b1);
        settle();
        chk("pe_proto", npe, p0 + 1);
        chk("pe_no_cmd", ncmd, n0);
        chk("pe_data_n", ndata, d0 + 1);
        if (dq.size() == 1) chk("pe_data", dq[0].b, 8'h55);
        else chk("pe_dq_size", dq.size(), 1);
        send_byte(8'hAF, 1'b0);
        settle();
        chk("pe_next_op", lop, 8'hAF);
        chk("pe_next_has", lhas, 0);
        chk("pe_next_count", ncmd, n0 + 1);

        // Display reset mid-byte
        send_byte(8'h81, 1'b0); send_byte(8'h20, 1'b0);
        settle();
        chk("res_pre_con", contrast, 8'h20);
        f0 = nfe;
        send_bits(8'hA5, 1'b0, 3);
        @(posedge clk); #1 oled_res_n = 1'b0;
        repeat (4) @(posedge clk); #1 oled_res_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("res_contrast", contrast, 8'h7F);
        chk("res_addr_mode", addr_mode, 2);
        chk("res_disp", disp_on, 0);
        chk("res_op", cmd_op, 0);
        chk("res_mux", mux_ratio, 63);
        @(posedge clk); #1;
        send_byte(8'hAF, 1'b0);
        settle();
        chk("res_next_op", lop, 8'hAF);
        chk("res_next_disp", disp_on, 1);
        chk("res_no_fe", nfe, f0);
        send_data_check(8'hC3, 7'd0, 3'd0, "res_data");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
